arith_writeback_stage: RTL and testbench

- Downstream neighbour of the arithmetic unit in the 19-bit CPU execute path.
- Accepts the arithmetic unit's result and metadata over a valid/ready handshake and buffers them in a 2-entry in-order queue.
- Writes results to the register file through a second handshake and maintains the architectural flag register {Z,N,C,V}.
- Exports a pending-destination mask so decode can stall on read-after-write hazards.

---
 rtl/arith_writeback_stage.sv | 113 +++++++++++
 tb/tb_arith_writeback_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_writeback_stage.sv
// Writeback stage behind the arithmetic unit: a 2-entry in-order result queue
// that drains into the register-file write port and maintains the {Z,N,C,V} flags.
module arith_writeback_stage #(
  parameter int WORD_SIZE  = 19,
  parameter int REG_ADDR_W = 3,
  parameter int NUM_REGS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [WORD_SIZE-1:0]  ex_result,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_wr_en,
  input  logic                  ex_flag_en,
  input  logic                  ex_carry,
  input  logic                  ex_ovf,
  output logic                  rf_wr_valid,
  input  logic                  rf_wr_ready,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [WORD_SIZE-1:0]  rf_wr_data,
  output logic [3:0]            flags,
  output logic [NUM_REGS-1:0]   pending,
  output logic [1:0]            occupancy
);

  // Both ports use valid/ready: a transfer happens on a rising edge where
  // valid && ready; once valid is raised its payload holds until that edge.

  logic [WORD_SIZE-1:0]  result_q [2];
  logic [REG_ADDR_W-1:0] dest_q   [2];
  logic [1:0]            wr_en_q, flag_en_q, carry_q, ovf_q;

  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] occ_q, occ_d;
  logic [3:0] flags_q, flags_d;

  logic accept, head_valid, head_wr_en, retire;

  // ex_ready looks only at occupancy, never at rf_wr_ready.
  assign ex_ready   = !rst && (occ_q < 2'd2);
  assign accept     = ex_valid && ex_ready;
  assign head_valid = !rst && (occ_q != 2'd0);
  assign head_wr_en = wr_en_q[rd_ptr_q];
  assign retire     = head_valid && (!head_wr_en || rf_wr_ready);

  always_comb begin
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q ^ retire;
    wr_ptr_d = wr_ptr_q ^ accept;
    flags_d  = flags_q;
    case ({accept, retire})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    if (retire && flag_en_q[rd_ptr_q]) begin
      flags_d = {(result_q[rd_ptr_q] == '0), result_q[rd_ptr_q][WORD_SIZE-1],
                 carry_q[rd_ptr_q], ovf_q[rd_ptr_q]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      flags_q  <= 4'b0000;
    end else begin
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      flags_q  <= flags_d;
    end
  end

  // Payload needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      result_q[wr_ptr_q]  <= ex_result;
      dest_q[wr_ptr_q]    <= ex_dest;
      wr_en_q[wr_ptr_q]   <= ex_wr_en;
      flag_en_q[wr_ptr_q] <= ex_flag_en;
      carry_q[wr_ptr_q]   <= ex_carry;
      ovf_q[wr_ptr_q]     <= ex_ovf;
    end
  end

  always_comb begin
    rf_wr_valid = head_valid && head_wr_en;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    if (rf_wr_valid) begin
      rf_wr_addr = dest_q[rd_ptr_q];
      rf_wr_data = result_q[rd_ptr_q];
    end
  end

  // A slot is live when the queue is full, or it is the head of a 1-entry queue.
  always_comb begin
    pending = '0;
    for (int i = 0; i < 2; i++) begin
      if (((occ_q == 2'd2) || ((occ_q == 2'd1) && (rd_ptr_q == i[0]))) && wr_en_q[i]) begin
        pending[dest_q[i]] = 1'b1;
      end
    end
  end

  assign flags     = flags_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_arith_writeback_stage.sv
// Bench for arith_writeback_stage: table of single ops with expected flags,
// hand sequences for stall/compare/stream/reset, and a randomized queue-model run.
module tb_arith_writeback_stage;

  localparam int W  = 19;
  localparam int AW = 3;
  localparam int SW = AW + W;

  typedef struct packed {
    logic [W-1:0]  result;
    logic [AW-1:0] dest;
    logic          wr_en;
    logic          flag_en;
    logic          carry;
    logic          ovf;
  } op_t;

  typedef struct packed {
    op_t       op;
    logic [7:0] exp_pend;
    logic [3:0] exp_flags;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid = 1'b0;
  logic          ex_ready;
  logic [W-1:0]  ex_result = '0;
  logic [AW-1:0] ex_dest = '0;
  logic          ex_wr_en = 1'b0, ex_flag_en = 1'b0, ex_carry = 1'b0, ex_ovf = 1'b0;
  logic          rf_wr_valid;
  logic          rf_wr_ready = 1'b0;
  logic [AW-1:0] rf_wr_addr;
  logic [W-1:0]  rf_wr_data;
  logic [3:0]    flags;
  logic [7:0]    pending;
  logic [1:0]    occupancy;

  arith_writeback_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result), .ex_dest(ex_dest),
    .ex_wr_en(ex_wr_en), .ex_flag_en(ex_flag_en), .ex_carry(ex_carry), .ex_ovf(ex_ovf),
    .rf_wr_valid(rf_wr_valid), .rf_wr_ready(rf_wr_ready), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .flags(flags), .pending(pending), .occupancy(occupancy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int wr_count = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [W-1:0] r, input logic [AW-1:0] d,
                             input logic we, input logic fe, input logic c, input logic v);
    op_t o;
    o.result = r; o.dest = d; o.wr_en = we; o.flag_en = fe; o.carry = c; o.ovf = v;
    return o;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  op_t           mq[$];
  logic [SW-1:0] exp_q[$];
  logic [3:0]    m_flags = 4'b0000;
  logic [7:0]    m_pend;
  logic          m_valid;
  op_t           m_cur;

  always @(negedge clk) begin
    if (mon_en) begin
      m_pend = '0;
      foreach (mq[i]) if (mq[i].wr_en) m_pend[mq[i].dest] = 1'b1;
      m_valid = !rst && (mq.size() > 0) && mq[0].wr_en;
      chk("mdl_occupancy", 32'(occupancy), 32'(mq.size()));
      chk("mdl_ex_ready", 32'(ex_ready), 32'(!rst && mq.size() < 2));
      chk("mdl_pending", 32'(pending), 32'(m_pend));
      chk("mdl_flags", 32'(flags), 32'(m_flags));
      chk("mdl_rf_wr_valid", 32'(rf_wr_valid), 32'(m_valid));
      chk("mdl_rf_wr_addr_data", 32'({rf_wr_addr, rf_wr_data}),
          m_valid ? 32'({mq[0].dest, mq[0].result}) : 32'd0);
      if (!rst && rf_wr_valid && rf_wr_ready) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL sb_unexpected_write: got write addr %0d data %0h, required none", rf_wr_addr, rf_wr_data);
        end else begin
          chk("sb_write_order", 32'({rf_wr_addr, rf_wr_data}), 32'(exp_q.pop_front()));
        end
      end
      // advance the model to the state after the coming edge
      if (rst) begin
        mq.delete(); exp_q.delete(); m_flags = 4'b0000;
      end else begin
        m_cur = mk(ex_result, ex_dest, ex_wr_en, ex_flag_en, ex_carry, ex_ovf);
        if (mq.size() > 0 && (!mq[0].wr_en || rf_wr_ready)) begin
          if (mq[0].flag_en)
            m_flags = {(mq[0].result == 0), mq[0].result[W-1], mq[0].carry, mq[0].ovf};
          void'(mq.pop_front());
        end
        if (ex_valid && mq.size() < 2 + ((occupancy != mq.size()) ? 0 : 0) && ex_ready) begin
          mq.push_back(m_cur);
          if (m_cur.wr_en) exp_q.push_back({m_cur.dest, m_cur.result});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic present(input op_t op);
    ex_result = op.result; ex_dest = op.dest; ex_wr_en = op.wr_en;
    ex_flag_en = op.flag_en; ex_carry = op.carry; ex_ovf = op.ovf;
    ex_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int waited = 0;
    forever begin
      @(negedge clk);
      if (ex_ready) break;
      waited++;
      if (waited > 100) begin
        n_cmp++; n_fail++;
        $display("FAIL accept_timeout: ex_ready low for %0d cycles, required <= 100", waited);
        break;
      end
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic send(input op_t op);
    present(op);
    wait_accept();
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[7];
  int   wrc0;
  time  t0;
  bit   rnd_done;
  op_t  rop;

  initial begin
    vecs[0] = '{op: mk(19'h00005, 3'd3, 1, 1, 0, 0), exp_pend: 8'h08, exp_flags: 4'b0000};
    vecs[1] = '{op: mk(19'h00000, 3'd1, 1, 1, 0, 0), exp_pend: 8'h02, exp_flags: 4'b1000};
    vecs[2] = '{op: mk(19'h40000, 3'd7, 1, 1, 1, 1), exp_pend: 8'h80, exp_flags: 4'b0111};
    vecs[3] = '{op: mk(19'h00001, 3'd2, 1, 0, 1, 1), exp_pend: 8'h04, exp_flags: 4'b0111};
    vecs[4] = '{op: mk(19'h7FFFF, 3'd0, 0, 1, 0, 1), exp_pend: 8'h00, exp_flags: 4'b0101};
    vecs[5] = '{op: mk(19'h00000, 3'd5, 0, 0, 1, 0), exp_pend: 8'h00, exp_flags: 4'b0101};
    vecs[6] = '{op: mk(19'h3FFFF, 3'd6, 1, 1, 1, 0), exp_pend: 8'h40, exp_flags: 4'b0010};

    // reset
    rst = 1'b1;
    @(posedge clk); #1; mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ex_ready_low", 32'(ex_ready), 32'd0);
    chk("rst_rf_wr_valid", 32'(rf_wr_valid), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("reset_occupancy", 32'(occupancy), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_ex_ready", 32'(ex_ready), 32'd1);
    chk("reset_rf_addr_data", 32'({rf_wr_addr, rf_wr_data}), 32'd0);
    @(posedge clk); #1;

    // table-driven single ops
    rf_wr_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].op);
      @(negedge clk);
      chk("vec_occupancy_head", 32'(occupancy), 32'd1);
      chk("vec_rf_wr_valid", 32'(rf_wr_valid), 32'(vecs[i].op.wr_en));
      chk("vec_pending_head", 32'(pending), 32'(vecs[i].exp_pend));
      if (vecs[i].op.wr_en)
        chk("vec_addr_data", 32'({rf_wr_addr, rf_wr_data}), 32'({vecs[i].op.dest, vecs[i].op.result}));
      @(negedge clk);
      chk("vec_flags", 32'(flags), 32'(vecs[i].exp_flags));
      chk("vec_pending_after", 32'(pending), 32'd0);
      chk("vec_occupancy_after", 32'(occupancy), 32'd0);
      @(posedge clk); #1;
    end

    // backpressure: third op held upstream, writes drain in order 1,2,3
    rf_wr_ready = 1'b0;
    wrc0 = wr_count;
    send(mk(19'h00011, 3'd1, 1, 0, 0, 0));
    send(mk(19'h00022, 3'd2, 1, 0, 0, 0));
    present(mk(19'h00033, 3'd3, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_occupancy_full", 32'(occupancy), 32'd2);
      chk("bp_ex_ready_low", 32'(ex_ready), 32'd0);
      chk("bp_pending", 32'(pending), 32'h06);
      chk("bp_head_hold", 32'({rf_wr_valid, rf_wr_addr, rf_wr_data}), 32'({1'b1, 3'd1, 19'h00011}));
    end
    @(posedge clk); #1; rf_wr_ready = 1'b1;
    wait_accept();
    repeat (4) @(negedge clk);
    chk("bp_write_count", 32'(wr_count - wrc0), 32'd3);
    @(posedge clk); #1;

    // flag-only compare retires without an RF handshake
    rf_wr_ready = 1'b0;
    send(mk(19'h00000, 3'd4, 0, 1, 0, 0));
    @(negedge clk);
    chk("cmp_rf_wr_valid", 32'(rf_wr_valid), 32'd0);
    chk("cmp_pending", 32'(pending), 32'd0);
    @(negedge clk);
    chk("cmp_occupancy", 32'(occupancy), 32'd0);
    chk("cmp_flags", 32'(flags), 32'b1000);
    @(posedge clk); #1;

    // streaming with wrap-around
    rf_wr_ready = 1'b1;
    wrc0 = wr_count;
    t0 = $time;
    for (int k = 0; k < 10; k++) send(mk(19'(32'h1000 + k * 32'h111), 3'(k), 1, 1, k[0], k[1]));
    chk("stream_cycles", 32'(($time - t0) / 10), 32'd10);
    @(negedge clk);
    chk("stream_occupancy", 32'(occupancy), 32'd1);
    @(negedge clk);
    chk("stream_write_count", 32'(wr_count - wrc0), 32'd10);
    chk("stream_drained", 32'(occupancy), 32'd0);
    @(posedge clk); #1;

    // reset mid-operation discards buffered entries
    rf_wr_ready = 1'b0;
    send(mk(19'h00123, 3'd4, 1, 1, 1, 0));
    send(mk(19'h40001, 3'd5, 1, 1, 0, 1));
    wrc0 = wr_count;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; rf_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_occupancy", 32'(occupancy), 32'd0);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    chk("mid_rst_no_write", 32'(wr_count - wrc0), 32'd0);
    @(posedge clk); #1;

    // randomized traffic against the queue model
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          rop.result  = ($urandom_range(0, 5) == 0) ? 19'h0 : 19'($urandom);
          rop.dest    = 3'($urandom_range(0, 7));
          rop.wr_en   = ($urandom_range(0, 4) != 0);
          rop.flag_en = 1'($urandom);
          rop.carry   = 1'($urandom);
          rop.ovf     = 1'($urandom);
          send(rop);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          rf_wr_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rf_wr_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rnd_exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("rnd_occupancy_final", 32'(occupancy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
